// File: rtl/w_fifo_pkg.sv
// ---------------------------------------------------------------------------
// w_fifo_pkg : shared types and width helpers for the async FIFO write side
// Revision   : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package w_fifo_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned c_data_width_dflt = 8;

  // Counter wide enough to hold the value n itself.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/w_port_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational rotate-priority finder, first set bit at/after rr_ptr
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [IDX_W-1:0] w_pos;

  // Walk offsets from the far end so the nearest valid index is written last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    w_pos  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if ((int'(rr_ptr) + i) >= N_REQ) begin
        w_pos = IDX_W'(int'(rr_ptr) + i - N_REQ);
      end else begin
        w_pos = IDX_W'(int'(rr_ptr) + i);
      end
      if (req[w_pos]) begin
        winner = w_pos;
        found  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/w_port_arbiter.sv
// ---------------------------------------------------------------------------
// w_port_arbiter : round-robin burst arbiter for the async FIFO write port
// Revision       : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module w_port_arbiter
  import w_fifo_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_WIDTH   = c_data_width_dflt,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                          w_clk,
  input  logic                          w_rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          w_full,
  output logic                          w_inc,
  output logic [DATA_WIDTH-1:0]         w_data,
  output logic [$clog2(N_REQ)-1:0]      grant_id,
  output logic                          busy
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int BEAT_W = cnt_w(MAX_BURST);
  localparam int IDLE_W = cnt_w(IDLE_TIMEOUT);

  localparam logic [BEAT_W-1:0] c_beat_last = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDLE_W-1:0] c_idle_last = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(N_REQ - 1);

  arb_state_e        r_state,    w_state_nxt;
  logic [IDX_W-1:0]  r_owner,    w_owner_nxt;
  logic [IDX_W-1:0]  r_rr_ptr,   w_rr_ptr_nxt;
  logic [BEAT_W-1:0] r_beat_cnt, w_beat_cnt_nxt;
  logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_nxt;

  logic [IDX_W-1:0]  w_winner;
  logic              w_found;
  logic              w_owner_valid;
  logic              w_owner_last;
  logic              w_xfer;
  logic              w_release;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (r_rr_ptr),
    .winner (w_winner),
    .found  (w_found)
  );

  assign w_owner_valid = req_valid[r_owner];
  assign w_owner_last  = req_last[r_owner];
  assign w_xfer        = (r_state == GRANT) && w_owner_valid && !w_full;

  // A stalled owner (valid but FIFO full) matches neither release term.
  assign w_release = (r_state == GRANT) &&
                     ((w_xfer && (w_owner_last || (r_beat_cnt == c_beat_last))) ||
                      (!w_owner_valid && (r_idle_cnt == c_idle_last)));

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state    <= ARB;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_idle_cnt_nxt = r_idle_cnt;
    case (r_state)
      ARB: begin
        if (w_found) begin
          w_owner_nxt    = w_winner;
          w_beat_cnt_nxt = '0;
          w_idle_cnt_nxt = '0;
          w_state_nxt    = GRANT;
        end
      end
      GRANT: begin
        if (w_xfer) begin
          w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          w_idle_cnt_nxt = '0;
        end else if (!w_owner_valid && (r_idle_cnt != '1)) begin
          w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end
        if (w_release) begin
          w_state_nxt  = ARB;
          w_rr_ptr_nxt = (r_owner == c_idx_last) ? '0 : r_owner + 1'b1;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_comb begin
    req_ready = '0;
    w_data    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == IDX_W'(i)) begin
        req_ready[i] = (r_state == GRANT) && !w_full;
        w_data       = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_inc    = w_xfer;
  assign grant_id = r_owner;
  assign busy     = (r_state == GRANT);

endmodule

`default_nettype wire

// File: tb/tb_w_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_w_port_arbiter : scoreboard bench for w_port_arbiter (default parameters)
// Revision          : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_w_port_arbiter;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last  = '0;
  logic [31:0] req_data  = '0;
  logic [3:0]  req_ready;
  logic        w_full = 1'b0;
  logic        w_inc;
  logic [7:0]  w_data;
  logic [1:0]  grant_id;
  logic        busy;

  logic [8:0]  rq [4][$];   // per-requester words {last, data}
  logic [9:0]  sb [$];      // expected writes {owner, data}
  logic [3:0]  acc;
  logic        s_inc, s_busy;
  logic [1:0]  s_gid;
  logic [3:0]  s_ready;
  int          n_tests = 0;
  int          n_fail  = 0;

  w_port_arbiter #(
    .N_REQ        (4),
    .DATA_WIDTH   (8),
    .MAX_BURST    (8),
    .IDLE_TIMEOUT (4)
  ) u_dut (
    .w_clk     (w_clk),
    .w_rst     (w_rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .w_full    (w_full),
    .w_inc     (w_inc),
    .w_data    (w_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic load(input int id, input logic [7:0] d, input logic last);
    rq[id].push_back({last, d});
  endtask

  task automatic drive();
    logic [8:0] w;
    for (int i = 0; i < 4; i++) begin
      if (rq[i].size() > 0) begin
        w = rq[i][0];
        req_valid[i]       = 1'b1;
        req_last[i]        = w[8];
        req_data[i*8 +: 8] = w[7:0];
      end else begin
        req_valid[i]       = 1'b0;
        req_last[i]        = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  // One cycle: sample at negedge, check, then advance requesters after the edge.
  task automatic step();
    logic [9:0] e;
    @(negedge w_clk);
    s_inc   = w_inc;
    s_busy  = busy;
    s_gid   = grant_id;
    s_ready = req_ready;
    chk_eq("inv_inc_full", {31'b0, w_inc & w_full}, 32'd0);
    chk_eq("inv_onehot0", {31'b0, $onehot0(req_ready)}, 32'd1);
    chk_eq("inv_inc_rdy", {31'b0, w_inc}, {31'b0, |(req_ready & req_valid)});
    chk_eq("inv_idle_inc", {31'b0, ~busy & w_inc}, 32'd0);
    if (w_inc) begin
      if (sb.size() == 0) begin
        chk_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk_eq("wr_owner", {30'b0, grant_id}, {30'b0, e[9:8]});
        chk_eq("wr_data", {24'b0, w_data}, {24'b0, e[7:0]});
      end
    end
    acc = req_ready & req_valid;
    @(posedge w_clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) void'(rq[i].pop_front());
    end
    drive();
  endtask

  task automatic do_reset();
    w_rst  = 1'b1;
    w_full = 1'b0;
    for (int i = 0; i < 4; i++) rq[i].delete();
    sb.delete();
    drive();
    #1;
    chk_eq("rst_inc", {31'b0, w_inc}, 32'd0);
    chk_eq("rst_busy", {31'b0, busy}, 32'd0);
    chk_eq("rst_gid", {30'b0, grant_id}, 32'd0);
    chk_eq("rst_ready", {28'b0, req_ready}, 32'd0);
    repeat (2) @(posedge w_clk);
    #1;
    w_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset then idle
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      chk_eq("t1_inc", {31'b0, s_inc}, 32'd0);
      chk_eq("t1_busy", {31'b0, s_busy}, 32'd0);
      chk_eq("t1_gid", {30'b0, s_gid}, 32'd0);
    end

    // 2: requester 2 always valid, no last: 8 beats, one ARB gap, 8 beats
    do_reset();
    for (int j = 0; j < 16; j++) begin
      load(2, 8'(j), 1'b0);
      sb.push_back({2'd2, 8'(j)});
    end
    drive();
    for (int c = 0; c < 19; c++) begin
      step();
      chk_eq("t2_inc", {31'b0, s_inc},
             {31'b0, ((c >= 1 && c <= 8) || (c >= 10 && c <= 17))});
    end
    chk_eq("t2_sb_left", sb.size(), 32'd0);

    // 3: all four valid, last every 3rd beat: order 0,1,2,3,0,1,2,3
    do_reset();
    for (int id = 0; id < 4; id++)
      for (int j = 0; j < 6; j++)
        load(id, 8'(16 * id + j), (j % 3) == 2);
    for (int r = 0; r < 2; r++)
      for (int id = 0; id < 4; id++)
        for (int k = 0; k < 3; k++)
          sb.push_back({2'(id), 8'(16 * id + 3 * r + k)});
    drive();
    for (int c = 0; c < 34; c++) begin
      step();
      chk_eq("t3_inc", {31'b0, s_inc}, {31'b0, (c >= 1 && c <= 31 && (c % 4) != 0)});
    end
    chk_eq("t3_sb_left", sb.size(), 32'd0);

    // 4: full for 5 cycles mid-burst of owner 1; beat count survives the stall
    do_reset();
    for (int j = 0; j < 8; j++) begin
      load(1, 8'(8'h40 + j), 1'b0);
      sb.push_back({2'd1, 8'(8'h40 + j)});
    end
    drive();
    for (int c = 0; c < 16; c++) begin
      w_full = (c >= 3 && c <= 7);
      step();
      chk_eq("t4_inc", {31'b0, s_inc},
             {31'b0, ((c >= 1 && c <= 2) || (c >= 8 && c <= 13))});
      chk_eq("t4_busy", {31'b0, s_busy}, {31'b0, (c >= 1 && c <= 13)});
      if (c >= 3 && c <= 7) begin
        chk_eq("t4_ready", {28'b0, s_ready}, 32'd0);
        chk_eq("t4_gid", {30'b0, s_gid}, 32'd1);
      end
    end
    w_full = 1'b0;
    chk_eq("t4_sb_left", sb.size(), 32'd0);

    // 5: owner 0 goes idle after 2 beats; timeout hands over to requester 1
    do_reset();
    load(0, 8'h50, 1'b0);
    load(0, 8'h51, 1'b0);
    load(1, 8'h58, 1'b0);
    load(1, 8'h59, 1'b0);
    load(1, 8'h5a, 1'b1);
    sb.push_back({2'd0, 8'h50});
    sb.push_back({2'd0, 8'h51});
    sb.push_back({2'd1, 8'h58});
    sb.push_back({2'd1, 8'h59});
    sb.push_back({2'd1, 8'h5a});
    drive();
    for (int c = 0; c < 13; c++) begin
      step();
      chk_eq("t5_inc", {31'b0, s_inc},
             {31'b0, ((c >= 1 && c <= 2) || (c >= 8 && c <= 10))});
      chk_eq("t5_busy", {31'b0, s_busy},
             {31'b0, ((c >= 1 && c <= 6) || (c >= 8 && c <= 10))});
      if (c == 8) chk_eq("t5_gid", {30'b0, s_gid}, 32'd1);
    end
    chk_eq("t5_sb_left", sb.size(), 32'd0);

    // 6: reset during beat 3 of owner 2, then arbitration restarts at index 0
    do_reset();
    load(0, 8'h60, 1'b1);
    for (int j = 0; j < 6; j++) load(2, 8'(8'h70 + j), 1'b0);
    sb.push_back({2'd0, 8'h60});
    sb.push_back({2'd2, 8'h70});
    sb.push_back({2'd2, 8'h71});
    sb.push_back({2'd2, 8'h72});
    drive();
    for (int c = 0; c < 5; c++) step();
    #1;
    chk_eq("t6_pre_inc", {31'b0, w_inc}, 32'd1);
    chk_eq("t6_pre_gid", {30'b0, grant_id}, 32'd2);
    #1;
    w_rst = 1'b1;
    #1;
    chk_eq("t6_async_inc", {31'b0, w_inc}, 32'd0);
    chk_eq("t6_async_busy", {31'b0, busy}, 32'd0);
    chk_eq("t6_async_gid", {30'b0, grant_id}, 32'd0);
    chk_eq("t6_async_ready", {28'b0, req_ready}, 32'd0);
    chk_eq("t6_sb_pending", sb.size(), 32'd1);
    do_reset();
    load(0, 8'h80, 1'b1);
    load(1, 8'h90, 1'b1);
    sb.push_back({2'd0, 8'h80});
    sb.push_back({2'd1, 8'h90});
    drive();
    for (int c = 0; c < 5; c++) begin
      step();
      chk_eq("t6_inc", {31'b0, s_inc}, {31'b0, (c == 1 || c == 3)});
    end
    chk_eq("t6_sb_left", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
